// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: instruction field layout, opcodes, FSM states.
package fetch_decode_stage_pkg;

    localparam int unsigned FIELD_W    = 5;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned RD_LSB     = 22;
    localparam int unsigned RS_LSB     = 17;
    localparam int unsigned RT_LSB     = 12;
    localparam int unsigned SHAMT_LSB  = 7;
    localparam int unsigned ALU_OP_LSB = 2;
    localparam int unsigned IMM_W      = 17;
    localparam int unsigned TARGET_W   = 27;

    localparam logic [FIELD_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [FIELD_W-1:0] OP_ADDI  = 5'b00101;
    localparam logic [FIELD_W-1:0] OP_SW    = 5'b00111;
    localparam logic [FIELD_W-1:0] OP_LW    = 5'b01000;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StPause
    } fetch_state_e;

    function automatic logic [31:0] sext_imm(input logic [31:0] instr);
        return {{(32 - IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Bundle of imem, redirect, fetch control and decoded-output handshake signals.
interface fetch_decode_stage_if #(
    parameter int unsigned PC_W = 12
) ();

    logic                                        fetch_en;
    logic [PC_W-1:0]                             address_imem;
    logic [31:0]                                 q_imem;
    logic                                        redirect_valid;
    logic [PC_W-1:0]                             redirect_pc;
    logic                                        out_valid;
    logic                                        out_ready;
    logic [PC_W-1:0]                             out_pc;
    logic [fetch_decode_stage_pkg::FIELD_W-1:0]  out_opcode;
    logic [fetch_decode_stage_pkg::FIELD_W-1:0]  out_rd;
    logic [fetch_decode_stage_pkg::FIELD_W-1:0]  out_rs;
    logic [fetch_decode_stage_pkg::FIELD_W-1:0]  out_rt;
    logic [fetch_decode_stage_pkg::FIELD_W-1:0]  out_shamt;
    logic [fetch_decode_stage_pkg::FIELD_W-1:0]  out_alu_op;
    logic [31:0]                                 out_imm;
    logic [fetch_decode_stage_pkg::TARGET_W-1:0] out_target;

    modport master (
        input  fetch_en, q_imem, redirect_valid, redirect_pc, out_ready,
        output address_imem, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_target
    );

    modport slave (
        output fetch_en, q_imem, redirect_valid, redirect_pc, out_ready,
        input  address_imem, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_alu_op, out_imm, out_target
    );

endinterface

// File: rtl/fetch_decode_stage_fifo.sv
// Synchronous FIFO with flush; flush overrides push and pop. Depth must be a power of two.
module fetch_decode_stage_fifo #(
    parameter int unsigned DataW = 44,
    parameter int unsigned Depth = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [DataW-1:0]           i_data,
    output logic [DataW-1:0]           o_data,
    output logic [$clog2(Depth):0]     o_count,
    output logic                       o_empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [DataW-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW:0]    r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PtrW + 1)'(1);
                2'b01:   r_count <= r_count - (PtrW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked by the caller while empty.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch + field split: PC/inflight tracking, BOOT/RUN/PAUSE FSM, buffered decode.
// Optional FETCH_PERF_CNT_EN adds pop and stall counters.
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter int unsigned     PC_W       = 12,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fetch_decode_stage_if.master io_bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          o_perf_fetched,
    output logic [31:0]          o_perf_stall
`endif
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DataW = 32 + PC_W;

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic             r_inflight;
    logic [PC_W-1:0]  r_inflight_pc;

    logic [CntW-1:0]  w_count;
    logic [DataW-1:0] w_head;
    logic             w_empty;
    logic             w_redirect;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [CntW:0]    w_occ;
    logic [31:0]      w_instr;
    logic [PC_W-1:0]  w_head_pc;

    assign w_redirect = io_bus.redirect_valid;
    assign w_valid    = ~w_empty & ~w_redirect;
    assign w_pop      = w_valid & io_bus.out_ready;
    // The word returning this cycle belongs to the old stream when redirecting.
    assign w_push     = r_inflight & ~w_redirect;
    assign w_occ      = (CntW + 1)'(w_count) + (CntW + 1)'(r_inflight) - (CntW + 1)'(w_pop);
    // fetch_en gates issue immediately; the FSM records the paused state.
    assign w_issue    = (r_state == StRun) & io_bus.fetch_en & ~w_redirect &
                        (w_occ < (CntW + 1)'(FIFO_DEPTH));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StBoot:  w_state_next = StRun;
            StRun:   if (!io_bus.fetch_en) w_state_next = StPause;
            StPause: if (io_bus.fetch_en) w_state_next = StRun;
            default: w_state_next = StBoot;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StBoot;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if (w_redirect) begin
                r_pc <= io_bus.redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_W'(1);
            end
            if (w_issue) r_inflight_pc <= r_pc;
        end
    end

    fetch_decode_stage_fifo #(
        .DataW (DataW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  ({io_bus.q_imem, r_inflight_pc}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign w_instr   = w_empty ? '0 : w_head[DataW-1:PC_W];
    assign w_head_pc = w_empty ? '0 : w_head[PC_W-1:0];

    assign io_bus.address_imem = r_pc;
    assign io_bus.out_valid    = w_valid;
    assign io_bus.out_pc       = w_head_pc;
    assign io_bus.out_opcode   = w_instr[OPCODE_LSB +: FIELD_W];
    assign io_bus.out_rd       = w_instr[RD_LSB +: FIELD_W];
    assign io_bus.out_rs       = w_instr[RS_LSB +: FIELD_W];
    assign io_bus.out_rt       = w_instr[RT_LSB +: FIELD_W];
    assign io_bus.out_shamt    = w_instr[SHAMT_LSB +: FIELD_W];
    assign io_bus.out_alu_op   = w_instr[ALU_OP_LSB +: FIELD_W];
    assign io_bus.out_imm      = sext_imm(w_instr);
    assign io_bus.out_target   = w_instr[TARGET_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_valid && !io_bus.out_ready) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: stream, decode, back-pressure, redirect, wrap, pause, perf.
module tb_fetch_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [4096];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fetch_decode_stage_if #(.PC_W(12)) bus_a ();
    fetch_decode_stage_if #(.PC_W(12)) bus_b ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_a, perf_stall_a, perf_fetched_b, perf_stall_b;
`endif

    fetch_decode_stage #(
        .PC_W       (12),
        .RESET_PC   (12'h000),
        .FIFO_DEPTH (2)
    ) u_dut_a (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .io_bus         (bus_a)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched (perf_fetched_a),
        .o_perf_stall   (perf_stall_a)
`endif
    );

    fetch_decode_stage #(
        .PC_W       (12),
        .RESET_PC   (12'hFFE),
        .FIFO_DEPTH (2)
    ) u_dut_b (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .io_bus         (bus_b)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_perf_fetched (perf_fetched_b),
        .o_perf_stall   (perf_stall_b)
`endif
    );

    // Synchronous imem: data valid one cycle after the address.
    always @(posedge clk) begin
        bus_a.q_imem <= imem[bus_a.address_imem];
        bus_b.q_imem <= imem[bus_b.address_imem];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = i;
        imem[0] = 32'h2842_0005;
        imem[1] = 32'h0001_FFFF;

        bus_a.fetch_en = 1'b1;  bus_a.out_ready = 1'b1;
        bus_a.redirect_valid = 1'b0;  bus_a.redirect_pc = 12'h000;
        bus_b.fetch_en = 1'b1;  bus_b.out_ready = 1'b1;
        bus_b.redirect_valid = 1'b0;  bus_b.redirect_pc = 12'h000;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_addr", 64'(bus_a.address_imem), 64'h000);
        chk("rst_opcode", 64'(bus_a.out_opcode), 64'd0);
        chk("rst_imm", 64'(bus_a.out_imm), 64'd0);
        chk("rst_pc_b", 64'(bus_b.address_imem), 64'hFFE);

        // Stream: BOOT exit, issue, capture
        rst_n = 1'b1;
        tick();
        chk("e0_addr", 64'(bus_a.address_imem), 64'h000);
        chk("e0_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        chk("e1_addr", 64'(bus_a.address_imem), 64'h001);
        chk("e1_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        chk("e2_valid", 64'(bus_a.out_valid), 64'd1);
        chk("e2_pc", 64'(bus_a.out_pc), 64'h000);
        chk("addi_opcode", 64'(bus_a.out_opcode), 64'h05);
        chk("addi_rd", 64'(bus_a.out_rd), 64'd1);
        chk("addi_rs", 64'(bus_a.out_rs), 64'd1);
        chk("addi_rt", 64'(bus_a.out_rt), 64'd0);
        chk("addi_shamt", 64'(bus_a.out_shamt), 64'd0);
        chk("addi_alu_op", 64'(bus_a.out_alu_op), 64'd1);
        chk("addi_imm", 64'(bus_a.out_imm), 64'd5);
        chk("addi_target", 64'(bus_a.out_target), 64'h042_0005);
        tick();
        chk("e3_pc", 64'(bus_a.out_pc), 64'h001);
        chk("neg_opcode", 64'(bus_a.out_opcode), 64'd0);
        chk("neg_imm", 64'(bus_a.out_imm), 64'hFFFF_FFFF);
        for (int k = 4; k <= 8; k++) begin
            tick();
            chk("stream_valid", 64'(bus_a.out_valid), 64'd1);
            chk("stream_pc", 64'(bus_a.out_pc), 64'(k - 2));
            chk("stream_addr", 64'(bus_a.address_imem), 64'(k));
        end

        // Back-pressure for 5 cycles
        bus_a.out_ready = 1'b0;
        for (int k = 9; k <= 13; k++) begin
            tick();
            chk("bp_valid", 64'(bus_a.out_valid), 64'd1);
            chk("bp_pc", 64'(bus_a.out_pc), 64'h006);
            chk("bp_imm", 64'(bus_a.out_imm), 64'd6);
            chk("bp_addr", 64'(bus_a.address_imem), 64'h008);
        end
        bus_a.out_ready = 1'b1;
        tick();
        chk("rel_pc7", 64'(bus_a.out_pc), 64'h007);
        chk("rel_addr9", 64'(bus_a.address_imem), 64'h009);
        tick();
        chk("rel_pc8", 64'(bus_a.out_pc), 64'h008);
        tick();
        chk("rel_pc9", 64'(bus_a.out_pc), 64'h009);
        chk("rel_addr11", 64'(bus_a.address_imem), 64'h00B);

        // Redirect with FIFO full
        bus_a.out_ready = 1'b0;
        tick();
        chk("full_addr", 64'(bus_a.address_imem), 64'h00B);
        chk("full_pc", 64'(bus_a.out_pc), 64'h009);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc = 12'h100;
        #1;
        chk("redir_valid_low", 64'(bus_a.out_valid), 64'd0);
        tick();
        bus_a.redirect_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        chk("redir_flush_valid", 64'(bus_a.out_valid), 64'd0);
        chk("redir_addr", 64'(bus_a.address_imem), 64'h100);
        tick();
        chk("redir_issue_addr", 64'(bus_a.address_imem), 64'h101);
        chk("redir_wait_valid", 64'(bus_a.out_valid), 64'd0);
        tick();
        chk("redir_first_valid", 64'(bus_a.out_valid), 64'd1);
        chk("redir_first_pc", 64'(bus_a.out_pc), 64'h100);
        chk("redir_first_imm", 64'(bus_a.out_imm), 64'h100);
        tick();
        chk("redir_second_pc", 64'(bus_a.out_pc), 64'h101);

        // Mid-run reset, then RESET_PC wrap and pause on instance b
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_a", 64'(bus_a.out_valid), 64'd0);
        chk("midrst_addr_a", 64'(bus_a.address_imem), 64'h000);
        chk("midrst_addr_b", 64'(bus_b.address_imem), 64'hFFE);
        tick();
        rst_n = 1'b1;
        tick();
        chk("wrap_f0_addr", 64'(bus_b.address_imem), 64'hFFE);
        tick();
        chk("wrap_f1_addr", 64'(bus_b.address_imem), 64'hFFF);
        chk("wrap_f1_valid", 64'(bus_b.out_valid), 64'd0);
        tick();
        chk("wrap_pc_ffe", 64'(bus_b.out_pc), 64'hFFE);
        chk("wrap_imm_ffe", 64'(bus_b.out_imm), 64'hFFE);
        chk("wrap_addr0", 64'(bus_b.address_imem), 64'h000);
        tick();
        chk("wrap_pc_fff", 64'(bus_b.out_pc), 64'hFFF);
        tick();
        chk("wrap_pc_000", 64'(bus_b.out_pc), 64'h000);
        chk("wrap_opcode0", 64'(bus_b.out_opcode), 64'h05);
        chk("wrap_addr2", 64'(bus_b.address_imem), 64'h002);
        bus_b.fetch_en = 1'b0;
        tick();
        chk("pause_inflight_valid", 64'(bus_b.out_valid), 64'd1);
        chk("pause_inflight_pc", 64'(bus_b.out_pc), 64'h001);
        chk("pause_addr_a", 64'(bus_b.address_imem), 64'h002);
        tick();
        chk("pause_drained", 64'(bus_b.out_valid), 64'd0);
        tick();
        chk("pause_addr_c", 64'(bus_b.address_imem), 64'h002);
        bus_b.fetch_en = 1'b1;
        tick();
        chk("resume_addr_hold", 64'(bus_b.address_imem), 64'h002);
        tick();
        chk("resume_addr_issue", 64'(bus_b.address_imem), 64'h003);
        tick();
        chk("resume_valid", 64'(bus_b.out_valid), 64'd1);
        chk("resume_pc", 64'(bus_b.out_pc), 64'h002);

`ifdef FETCH_PERF_CNT_EN
        // 10 pops and 4 stall cycles on instance a
        rst_n = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_a.fetch_en = 1'b1;
        #1;
        chk("perf_rst_fetched", 64'(perf_fetched_a), 64'd0);
        chk("perf_rst_stall", 64'(perf_stall_a), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        bus_a.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        bus_a.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("perf_fetched", 64'(perf_fetched_a), 64'd10);
        chk("perf_stall", 64'(perf_stall_a), 64'd4);
        rst_n = 1'b0;
        #1;
        chk("perf_midrst_fetched", 64'(perf_fetched_a), 64'd0);
        chk("perf_midrst_stall", 64'(perf_stall_a), 64'd0);
        tick();
        rst_n = 1'b1;
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
